sme_hash_lookup: RTL and testbench
==================================

// Module: sme_hash_lookup
// PURPOSE
//  Hash-table lookup stage of the string-matching engine. Consumes two-lane multiplier hash products and
//  drives the address ports of an external 2-port hash ROM with fixed 2-cycle read latency. Realigns ROM
//  data with its lane mask and tag, drops beats with no hit, and buffers hits in a credit-protected FIFO.
//  The ROM pipeline cannot stall, so the FIFO absorbs downstream backpressure.
// PARAMETERS
//  HWIDTH     37  hash product width per lane
//  AWIDTH     12  ROM address width; addr = hash[SHIFT +: AWIDTH]
//  SHIFT      10  LSB of address slice; SHIFT+AWIDTH <= HWIDTH
//  DWIDTH     16  ROM word (rule id); 0 = empty slot
//  TAG_WIDTH  16  sideband (byte position) carried with each beat
//  ROM_LAT    2   ROM read latency, cycles
//  FIFO_DEPTH 8   output FIFO entries; power of 2, >= ROM_LAT+2
// PORTS
//  clk          in   1            clock
//  rst_n        in   1            async reset, active low
//  in_valid     in   1            input beat valid
//  in_ready     out  1            input accepted when in_valid && in_ready
//  in_lane_vld  in   2            per-lane valid, bit0 = lane a
//  in_hash_a    in   HWIDTH       lane a hash product
//  in_hash_b    in   HWIDTH       lane b hash product
//  in_tag       in   TAG_WIDTH    sideband
//  rom_addr_a   out  AWIDTH       ROM port a address, combinational from in_hash_a
//  rom_addr_b   out  AWIDTH       ROM port b address
//  rom_q_a      in   DWIDTH       ROM port a data, ROM_LAT cycles after address
//  rom_q_b      in   DWIDTH       ROM port b data
//  out_valid    out  1            FIFO head valid
//  out_ready    in   1            pop when out_valid && out_ready
//  out_hit      out  2            per-lane hit mask
//  out_rule_a   out  DWIDTH       lane a rule id, 0 when no hit
//  out_rule_b   out  DWIDTH       lane b rule id
//  out_tag      out  TAG_WIDTH    sideband of the beat
// BEHAVIOUR
//  - Reset: in_ready=0 during reset, 1 on first cycle after; out_valid=0; out_hit/rules/tag=0;
//    credits=FIFO_DEPTH; valid pipe cleared; in-flight beats discarded.
//  - Credits: decrement on accept; increment on drop or FIFO pop. in_ready = (credits != 0), registered.
//    Accept and return in the same cycle leave credits unchanged. Credits never exceed FIFO_DEPTH.
//  - rom_addr_x = in_hash_x[SHIFT +: AWIDTH] at all times. Upper and lower hash bits are ignored.
//  - Valid pipe: ROM_LAT-stage shift register of {accepted, lane_vld, tag}, advancing every cycle.
//  - Resolve stage: beat accepted in cycle T resolves in T+ROM_LAT. hit_x = lane_vld_x && rom_q_x != 0.
//    Any hit: push {hit, q masked by hit, tag} into FIFO. Otherwise drop and return one credit.
//  - Beats with lane_vld=0 are accepted, consume a credit and are dropped at resolve.
//  - Latency: accept at T, FIFO empty -> out_valid at T+ROM_LAT+1 (3 cycles by default).
//  - Ordering is strictly preserved. The FIFO can never overflow; overflow assertion in simulation.
//  - Push into an empty FIFO with a simultaneous pop is legal; head updates the next cycle.
// CONFIGURATION
//  HASH_LOOKUP_STATS_EN defined: adds ports
//    stat_clr in 1, stat_beats_in out 32, stat_beats_drop out 32, stat_lane_hits out 32.
//    Counters saturate at all-ones, reset to 0, and clear synchronously on stat_clr.
//    stat_clr has priority over an increment in the same cycle.
//  Not defined: ports and counters are absent; datapath behaviour is identical.
// STRUCTURE
//  Package sme_hash_pkg: lookup_entry_t struct {hit, rule_a, rule_b, tag}, default widths,
//    and an ADDR_SLICE helper function.
//  Sub-module sme_lookup_fifo: sync FIFO of lookup_entry_t with registered show-ahead head.
//  Top holds the credit counter, valid pipe, resolve logic and optional stats.
// TESTING
//  1 Beat in_hash_a=0xC00, lane_vld=01, ROM[3]=0x0042 -> rom_addr_a=3; out at T+3: hit=01, rule_a=0x42, rule_b=0.
//  2 Both lanes valid, ROM words 0 -> no output; in_ready stays 1; credits back to 8 at T+2.
//  3 out_ready=0, 12 back-to-back hit beats tag 0..11 -> 8 accepted, in_ready low;
//    release -> tags 0..7 in order, then the remaining beats.
//  4 Credits=1: accept beat while an older beat drops in the same cycle -> credits stay 1, in_ready stays 1.
//  5 rst_n low with 3 beats in flight -> out_valid=0, no stale output after release, in_ready=1 one cycle later.
//  6 HASH_LOOKUP_STATS_EN: 5 beats, 2 drops, 4 lane hits -> counters 5/2/4; stat_clr -> 0/0/0.

Source files
------------

// File: rtl/sme_hash_pkg.sv
// Shared types and default widths for the hash lookup stage of the string-matching engine.
// The lookup entry struct is sized by the package defaults, which the top-level parameters also default to.
package sme_hash_pkg;

  localparam int HWIDTH_D     = 37;
  localparam int AWIDTH_D     = 12;
  localparam int SHIFT_D      = 10;
  localparam int DWIDTH_D     = 16;
  localparam int TAG_WIDTH_D  = 16;
  localparam int ROM_LAT_D    = 2;
  localparam int FIFO_DEPTH_D = 8;

  typedef struct packed {
    logic [1:0]             hit;
    logic [DWIDTH_D-1:0]    rule_a;
    logic [DWIDTH_D-1:0]    rule_b;
    logic [TAG_WIDTH_D-1:0] tag;
  } lookup_entry_t;

  function automatic logic [AWIDTH_D-1:0] addr_slice(input logic [HWIDTH_D-1:0] hash);
    return hash[SHIFT_D +: AWIDTH_D];
  endfunction

endpackage

// File: rtl/sme_lookup_fifo.sv
// Synchronous FIFO of lookup entries with a registered show-ahead head.
// The head register is loaded from the incoming entry when it becomes the oldest one.
module sme_lookup_fifo
  import sme_hash_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_D
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  lookup_entry_t din,
  input  logic          pop,
  output logic          head_vld,
  output lookup_entry_t head
);

  localparam int PW = $clog2(DEPTH);

  lookup_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [PW:0]   count, count_nxt;
  logic          pop_ok;

  assign pop_ok     = pop && head_vld;
  assign rd_ptr_nxt = rd_ptr + PW'(pop_ok);
  assign count_nxt  = count + (PW+1)'(push) - (PW+1)'(pop_ok);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // The new head bypasses storage when it is the entry being written this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_vld <= 1'b0;
      head     <= '0;
    end else begin
      wr_ptr   <= wr_ptr + PW'(push);
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      head_vld <= (count_nxt != '0);
      if (count_nxt == '0)
        head <= '0;
      else if (push && rd_ptr_nxt == wr_ptr)
        head <= din;
      else
        head <= mem[rd_ptr_nxt];
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop_ok && count == (PW+1)'(DEPTH)));
`endif

endmodule

// File: rtl/sme_hash_lookup.sv
// Hash-table lookup stage: drives ROM addresses, realigns ROM data with lane mask and tag, queues hits.
// Optional statistics counters are enabled by defining HASH_LOOKUP_STATS_EN.
module sme_hash_lookup
  import sme_hash_pkg::*;
#(
  parameter int HWIDTH     = HWIDTH_D,
  parameter int AWIDTH     = AWIDTH_D,
  parameter int SHIFT      = SHIFT_D,
  parameter int DWIDTH     = DWIDTH_D,
  parameter int TAG_WIDTH  = TAG_WIDTH_D,
  parameter int ROM_LAT    = ROM_LAT_D,
  parameter int FIFO_DEPTH = FIFO_DEPTH_D
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef HASH_LOOKUP_STATS_EN
  input  logic                 stat_clr,
  output logic [31:0]          stat_beats_in,
  output logic [31:0]          stat_beats_drop,
  output logic [31:0]          stat_lane_hits,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_lane_vld,
  input  logic [HWIDTH-1:0]    in_hash_a,
  input  logic [HWIDTH-1:0]    in_hash_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic [AWIDTH-1:0]    rom_addr_a,
  output logic [AWIDTH-1:0]    rom_addr_b,
  input  logic [DWIDTH-1:0]    rom_q_a,
  input  logic [DWIDTH-1:0]    rom_q_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_hit,
  output logic [DWIDTH-1:0]    out_rule_a,
  output logic [DWIDTH-1:0]    out_rule_b,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0]        credits, credits_nxt;
  logic                 accept, push, drop, pop;
  logic                 vld_p  [ROM_LAT];
  logic [1:0]           lane_p [ROM_LAT];
  logic [TAG_WIDTH-1:0] tag_p  [ROM_LAT];
  logic [1:0]           hit_p;
  lookup_entry_t        entry, head;
  logic                 unused_hash;

  // Stage 0: address issue and credit accounting
  assign rom_addr_a  = in_hash_a[SHIFT +: AWIDTH];
  assign rom_addr_b  = in_hash_b[SHIFT +: AWIDTH];
  assign unused_hash = ^{in_hash_a, in_hash_b};

  assign accept      = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign credits_nxt = credits - CW'(accept) + CW'(drop) + CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits  <= CW'(FIFO_DEPTH);
      in_ready <= 1'b0;
    end else begin
      credits  <= credits_nxt;
      in_ready <= (credits_nxt != '0);
    end
  end

  // Stages 1..ROM_LAT: beat context travels alongside the ROM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < ROM_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    lane_p[0] <= in_lane_vld;
    tag_p[0]  <= in_tag;
    for (int i = 1; i < ROM_LAT; i++) begin
      lane_p[i] <= lane_p[i-1];
      tag_p[i]  <= tag_p[i-1];
    end
  end

  // Resolve: ROM data lines up with the last pipe stage
  always_comb begin
    entry        = '0;
    hit_p        = lane_p[ROM_LAT-1] & {rom_q_b != '0, rom_q_a != '0};
    push         = vld_p[ROM_LAT-1] && (hit_p != 2'b00);
    drop         = vld_p[ROM_LAT-1] && (hit_p == 2'b00);
    entry.hit    = hit_p;
    entry.rule_a = hit_p[0] ? rom_q_a : '0;
    entry.rule_b = hit_p[1] ? rom_q_b : '0;
    entry.tag    = tag_p[ROM_LAT-1];
  end

  sme_lookup_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .din      (entry),
    .pop      (pop),
    .head_vld (out_valid),
    .head     (head)
  );

  assign out_hit    = head.hit;
  assign out_rule_a = head.rule_a;
  assign out_rule_b = head.rule_b;
  assign out_tag    = head.tag;

`ifdef HASH_LOOKUP_STATS_EN
  logic [1:0] lane_hit_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, acc} + {31'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  assign lane_hit_inc = vld_p[ROM_LAT-1] ? (2'(hit_p[0]) + 2'(hit_p[1])) : 2'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats_in   <= '0;
      stat_beats_drop <= '0;
      stat_lane_hits  <= '0;
    end else if (stat_clr) begin
      stat_beats_in   <= '0;
      stat_beats_drop <= '0;
      stat_lane_hits  <= '0;
    end else begin
      stat_beats_in   <= sat_add(stat_beats_in, {1'b0, accept});
      stat_beats_drop <= sat_add(stat_beats_drop, {1'b0, drop});
      stat_lane_hits  <= sat_add(stat_lane_hits, lane_hit_inc);
    end
  end
`endif

endmodule

// File: tb/tb_sme_hash_lookup.sv
// Randomized bench for sme_hash_lookup against a queue-based transaction model.
// Define HASH_LOOKUP_STATS_EN to also exercise the statistics counters.
`timescale 1ns/1ps
module tb_sme_hash_lookup;

  localparam int HW = 37, AW = 12, SH = 10, DW = 16, TW = 16, DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [1:0]    in_lane_vld = 2'b00;
  logic [HW-1:0] in_hash_a = '0, in_hash_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic [AW-1:0] rom_addr_a, rom_addr_b;
  logic [DW-1:0] rom_q_a, rom_q_b;
  logic          out_valid, out_ready = 1'b0;
  logic [1:0]    out_hit;
  logic [DW-1:0] out_rule_a, out_rule_b;
  logic [TW-1:0] out_tag;
`ifdef HASH_LOOKUP_STATS_EN
  logic          stat_clr = 1'b0;
  logic [31:0]   stat_beats_in, stat_beats_drop, stat_lane_hits;
`endif

  int n_vec = 0, n_miss = 0;

  always #5 clk = ~clk;

  sme_hash_lookup dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef HASH_LOOKUP_STATS_EN
    .stat_clr        (stat_clr),
    .stat_beats_in   (stat_beats_in),
    .stat_beats_drop (stat_beats_drop),
    .stat_lane_hits  (stat_lane_hits),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_lane_vld(in_lane_vld),
    .in_hash_a  (in_hash_a),
    .in_hash_b  (in_hash_b),
    .in_tag     (in_tag),
    .rom_addr_a (rom_addr_a),
    .rom_addr_b (rom_addr_b),
    .rom_q_a    (rom_q_a),
    .rom_q_b    (rom_q_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_hit    (out_hit),
    .out_rule_a (out_rule_a),
    .out_rule_b (out_rule_b),
    .out_tag    (out_tag)
  );

  // External ROM with a two-cycle read latency
  logic [DW-1:0] rom [0:(1<<AW)-1];
  logic [DW-1:0] qa_d1, qb_d1;
  always @(posedge clk) begin
    qa_d1   <= rom[rom_addr_a];
    qb_d1   <= rom[rom_addr_b];
    rom_q_a <= qa_d1;
    rom_q_b <= qb_d1;
  end

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Transaction model: outstanding beats, expected output queue and pending credit returns
  typedef struct {
    logic [1:0]    hit;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic [TW-1:0] tag;
    int            rdy;
  } exp_t;

  exp_t exp_q[$];
  int   drop_q[$];
  int   ec = 0;
  int   outstanding = 0;
  bit   armed = 1'b0;

  function automatic logic [AW-1:0] haddr(input logic [HW-1:0] h);
    return AW'((h / (64'd1 << SH)) % (64'd1 << AW));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      drop_q.delete();
      outstanding = 0;
      armed = 1'b0;
    end else begin
      bit   rdy_pre, vld_pre, acc, pop;
      int   nd;
      exp_t e;
      logic [DW-1:0] qa, qb;
      rdy_pre = armed && (outstanding < DEPTH);
      vld_pre = (exp_q.size() > 0) && (exp_q[0].rdy <= ec);
      acc = in_valid && rdy_pre;
      pop = out_ready && vld_pre;
      ec++;
      if (pop) void'(exp_q.pop_front());
      nd = 0;
      while (drop_q.size() > 0 && drop_q[0] == ec) begin
        void'(drop_q.pop_front());
        nd++;
      end
      if (acc) begin
        qa = rom[haddr(in_hash_a)];
        qb = rom[haddr(in_hash_b)];
        e.hit = {in_lane_vld[1] && qb != 0, in_lane_vld[0] && qa != 0};
        e.ra  = e.hit[0] ? qa : '0;
        e.rb  = e.hit[1] ? qb : '0;
        e.tag = in_tag;
        e.rdy = ec + 2;
        if (e.hit != 2'b00) exp_q.push_back(e);
        else drop_q.push_back(ec + 2);
      end
      outstanding = outstanding + int'(acc) - int'(pop) - nd;
      armed = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk_eq("rst_in_ready", in_ready, 0);
      chk_eq("rst_out_valid", out_valid, 0);
      chk_eq("rst_head", {out_hit, out_rule_a, out_rule_b, out_tag}, 0);
    end else begin
      bit vld_m;
      vld_m = (exp_q.size() > 0) && (exp_q[0].rdy <= ec);
      chk_eq("in_ready", in_ready, armed && (outstanding < DEPTH));
      chk_eq("out_valid", out_valid, vld_m);
      if (vld_m)
        chk_eq("out_data", {out_hit, out_rule_a, out_rule_b, out_tag},
               {exp_q[0].hit, exp_q[0].ra, exp_q[0].rb, exp_q[0].tag});
      if (in_valid) begin
        chk_eq("rom_addr_a", rom_addr_a, haddr(in_hash_a));
        chk_eq("rom_addr_b", rom_addr_b, haddr(in_hash_b));
      end
    end
  end

  task automatic drive(input logic [HW-1:0] ha, input logic [HW-1:0] hb,
                       input logic [1:0] lv, input logic [TW-1:0] tg);
    bit ok;
    in_hash_a = ha; in_hash_b = hb; in_lane_vld = lv; in_tag = tg; in_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) begin
        in_valid = 1'b0;
        return;
      end
    end
    chk_eq("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && outstanding == 0) return;
    end
    chk_eq("drain_timeout", 0, 1);
  endtask

  function automatic logic [HW-1:0] mk_hash(input logic [AW-1:0] a);
    logic [HW-1:0] h;
    h = HW'({$urandom, $urandom});
    h[SH +: AW] = a;
    return h;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = ($urandom % 2) ? DW'($urandom) : '0;
    rom[3] = 16'h0042; rom[5] = '0; rom[6] = '0; rom[7] = 16'h0777; rom[9] = 16'h0999;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Single lane-a hit, lane b masked off even though its word is non-zero
    drive(37'h0000000C00, mk_hash(12'd7), 2'b01, 16'h0001);
    idle(6);

    // Both lanes valid but ROM words empty: beat is dropped
    drive(mk_hash(12'd5), mk_hash(12'd6), 2'b11, 16'h0002);
    idle(6);

    // Backpressure fills the credit window, then release
    out_ready = 1'b0;
    fork
      for (int t = 0; t < 12; t++) drive(mk_hash(12'd7), mk_hash(12'd9), 2'b11, TW'(t));
      begin idle(30); out_ready = 1'b1; end
    join
    drain();

    // Credit return from a drop coincides with an accept at one credit left
    out_ready = 1'b0;
    for (int t = 0; t < 6; t++) drive(mk_hash(12'd3), mk_hash(12'd5), 2'b01, TW'(16'h100 + t));
    drive(mk_hash(12'd5), mk_hash(12'd6), 2'b11, 16'h0200);
    idle(1);
    drive(mk_hash(12'd9), mk_hash(12'd9), 2'b10, 16'h0201);
    idle(4);
    drain();

    // Reset with beats in flight
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) drive(mk_hash(12'd7), mk_hash(12'd3), 2'b11, TW'(16'h300 + t));
    #2 rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(8);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      in_valid    = ($urandom % 4) != 0;
      in_lane_vld = 2'($urandom);
      in_hash_a   = HW'({$urandom, $urandom});
      in_hash_b   = HW'({$urandom, $urandom});
      in_tag      = TW'($urandom);
      out_ready   = ($urandom % 3) != 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

`ifdef HASH_LOOKUP_STATS_EN
    stat_clr = 1'b1; idle(1); stat_clr = 1'b0;
    drive(mk_hash(12'd7), mk_hash(12'd9), 2'b11, 16'h0401);
    drive(mk_hash(12'd3), mk_hash(12'd5), 2'b11, 16'h0402);
    drive(mk_hash(12'd5), mk_hash(12'd9), 2'b11, 16'h0403);
    drive(mk_hash(12'd7), mk_hash(12'd7), 2'b00, 16'h0404);
    drive(mk_hash(12'd5), mk_hash(12'd6), 2'b11, 16'h0405);
    drain();
    chk_eq("stat_beats_in", stat_beats_in, 5);
    chk_eq("stat_beats_drop", stat_beats_drop, 2);
    chk_eq("stat_lane_hits", stat_lane_hits, 4);
    stat_clr = 1'b1; idle(1); stat_clr = 1'b0;
    chk_eq("stat_clr_in", stat_beats_in, 0);
    chk_eq("stat_clr_drop", stat_beats_drop, 0);
    chk_eq("stat_clr_hits", stat_lane_hits, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
